fb_buffer_ctl: RTL and testbench
================================

// Module: fb_buffer_ctl
// PURPOSE
//   Double-buffer controller for the two single-port framebuffer RAMs (A, B).
//   Routes the VGA frame reader to the display buffer and the sprite drawer to the draw buffer.
//   Clears the draw buffer after every swap, and swaps the buffers only in vertical blanking.
//   Sits between the frame controller, the sprite controller and the fb RAM pair; owns frame_num.
// PARAMETERS
//   ADDR_W       18      framebuffer address width
//   DATA_W       8       pixel (palette index) width
//   FB_DEPTH     76800   words cleared per buffer (320x240); must be <= 2**ADDR_W
//   CLEAR_COLOR  8'h00   palette index written by the clear engine
// PORTS
//   SYS_CLK      in   1       system clock; all logic on rising edge
//   RESET_N      in   1       asynchronous, active-low reset (KEY[0])
//   vblank_start in   1       1-cycle pulse at start of vertical blanking, from frame controller
//   rd_addr      in   ADDR_W  display-buffer read address from frame controller
//   rd_data      out  DATA_W  display-buffer pixel; 1-cycle latency after rd_addr
//   wr_req       in   1       sprite drawer pixel write request
//   wr_addr      in   ADDR_W  sprite drawer write address
//   wr_data      in   DATA_W  sprite drawer pixel
//   wr_ready     out  1       1 = draw buffer accepts writes this cycle
//   frame_done   in   1       1-cycle pulse: drawer finished the frame, request a swap
//   frame_num    out  1       0: A displayed / B drawn; 1: B displayed / A drawn
//   clearing     out  1       clear engine active
//   swap_done    out  1       1-cycle pulse in the cycle frame_num toggles
//   fbA_addr, fbB_addr  out  ADDR_W  RAM address
//   fbA_data, fbB_data  out  DATA_W  RAM write data
//   fbA_wren, fbB_wren  out  1       RAM write enable
//   fbA_q,    fbB_q     in   DATA_W  RAM read data, 1-cycle registered latency
// BEHAVIOUR
//   Reset (async):
//     - frame_num=0, state=CLEAR, clr_cnt=0, wr_ready=0, swap_done=0, rd_sel_q=0.
//     - Both wren=0 while RESET_N=0. A reset mid-clear or mid-draw abandons the operation; the clear restarts at 0.
//   Display side (combinational):
//     - Display RAM address = rd_addr; display RAM wren is always 0.
//     - rd_sel_q <= frame_num each cycle.
//     - rd_data = rd_sel_q ? fbB_q : fbA_q, so data returned across a swap edge comes from the buffer that was addressed.
//   Draw side: draw RAM = (frame_num ? A : B). Address, data and wren are muxed by state:
//     CLEAR: addr=clr_cnt, data=CLEAR_COLOR, wren=1, wr_ready=0, clearing=1.
//       - clr_cnt increments by 1 each cycle.
//       - At clr_cnt==FB_DEPTH-1 (that write done): go to DRAW and reset clr_cnt to 0.
//       - Takes exactly FB_DEPTH cycles.
//     DRAW: wr_ready=1; addr=wr_addr, data=wr_data, wren=wr_req (same-cycle write, no back-pressure).
//       - frame_done -> WAIT_VBL. A wr_req in the same cycle is still written.
//     WAIT_VBL: wr_ready=0, wren=0.
//       - wr_req is ignored; the drawer must respect wr_ready.
//       - vblank_start -> SWAP.
//     SWAP: one cycle; frame_num toggles; swap_done=1; wren=0; then CLEAR.
//   Event rules:
//     - frame_done is ignored outside DRAW.
//     - vblank_start is ignored outside WAIT_VBL.
//     - frame_done and vblank_start in the same DRAW cycle: only frame_done acts; the swap waits for the next vblank_start.
//     - Minimum frame period is FB_DEPTH+3 cycles; a frame_done arriving later simply holds the display (no tearing).
// TESTING  (FB_DEPTH=16, CLEAR_COLOR=8'h00 unless stated)
//   - Reset then run: clearing=1 for exactly 16 cycles; fbB_wren=1 at addr 0..15 with data 0; then wr_ready=1, frame_num=0.
//   - In DRAW: write wr_addr=5, wr_data=8'hF0 -> fbB_wren=1, addr 5. frame_done -> WAIT_VBL; vblank_start -> swap_done, frame_num=1. rd_addr=5 -> rd_data=8'hF0 one cycle later.
//   - After the swap: fbA cleared 0..15 with fbB_wren=0 throughout. A reader at rd_addr=5 keeps seeing 8'hF0 during the clear.
//   - frame_done and vblank_start in the same cycle: no swap; the next vblank_start swaps. wr_req in WAIT_VBL -> no wren on either RAM.
//   - Assert RESET_N=0 at clr_cnt=7 after a swap -> frame_num=0, wren=0 immediately; on release the clear restarts at addr 0 on fbB.
//   - CLEAR_COLOR=8'h3C, 3 consecutive frames: frame_num toggles 0->1->0->1; each drawn buffer reads 8'h3C at unwritten addresses.

Source files
------------

// File: rtl/fb_buffer_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : fb_buffer_ctl
//  Description : Double-buffer controller for the framebuffer RAM pair (A/B).
//                Display reads one buffer while the drawer fills and clears
//                the other; buffers swap only in vertical blanking.
//  Revision    : 1.0  initial release
// ============================================================================
module fb_buffer_ctl #(
    parameter int                ADDR_W      = 18,
    parameter int                DATA_W      = 8,
    parameter int                FB_DEPTH    = 76800,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
    input  logic              SYS_CLK,
    input  logic              RESET_N,
    input  logic              vblank_start,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              frame_done,
    output logic              frame_num,
    output logic              clearing,
    output logic              swap_done,
    output logic [ADDR_W-1:0] fbA_addr,
    output logic [ADDR_W-1:0] fbB_addr,
    output logic [DATA_W-1:0] fbA_data,
    output logic [DATA_W-1:0] fbB_data,
    output logic              fbA_wren,
    output logic              fbB_wren,
    input  logic [DATA_W-1:0] fbA_q,
    input  logic [DATA_W-1:0] fbB_q
);

    typedef enum logic [1:0] {
        S_CLEAR    = 2'd0,
        S_DRAW     = 2'd1,
        S_WAIT_VBL = 2'd2,
        S_SWAP     = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(FB_DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_frame_num;
    logic              r_rd_sel;
    logic              r_wr_ready;
    logic              r_clearing;
    logic              r_swap_done;

    logic [ADDR_W-1:0] w_draw_addr;
    logic [DATA_W-1:0] w_draw_data;
    logic              w_draw_wren;
    logic              w_wren;

    // Status outputs are registered alongside the state so they change with it.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_CLEAR;
            r_clr_cnt   <= '0;
            r_frame_num <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_wr_ready  <= 1'b0;
            r_clearing  <= 1'b1;
            r_swap_done <= 1'b0;
        end else begin
            r_rd_sel    <= r_frame_num;
            r_swap_done <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_cnt == c_last_addr) begin
                        r_state    <= S_DRAW;
                        r_clr_cnt  <= '0;
                        r_clearing <= 1'b0;
                        r_wr_ready <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                S_DRAW: begin
                    if (frame_done) begin
                        r_state    <= S_WAIT_VBL;
                        r_wr_ready <= 1'b0;
                    end
                end
                S_WAIT_VBL: begin
                    if (vblank_start) begin
                        r_state     <= S_SWAP;
                        r_frame_num <= ~r_frame_num;
                        r_swap_done <= 1'b1;
                    end
                end
                S_SWAP: begin
                    r_state    <= S_CLEAR;
                    r_clearing <= 1'b1;
                end
                default: begin
                    r_state <= S_CLEAR;
                end
            endcase
        end
    end

    always_comb begin
        w_draw_addr = wr_addr;
        w_draw_data = wr_data;
        w_draw_wren = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_draw_addr = r_clr_cnt;
                w_draw_data = CLEAR_COLOR;
                w_draw_wren = 1'b1;
            end
            S_DRAW: begin
                w_draw_wren = wr_req;
            end
            default: begin
                w_draw_wren = 1'b0;
            end
        endcase
    end

    // The reset state is CLEAR, so the strobe is gated to keep both RAMs quiet in reset.
    assign w_wren = w_draw_wren & RESET_N;

    assign fbA_addr = r_frame_num ? w_draw_addr : rd_addr;
    assign fbB_addr = r_frame_num ? rd_addr : w_draw_addr;
    assign fbA_data = w_draw_data;
    assign fbB_data = w_draw_data;
    assign fbA_wren = r_frame_num & w_wren;
    assign fbB_wren = ~r_frame_num & w_wren;

    // Select follows the buffer that was addressed, not the current frame_num.
    assign rd_data   = r_rd_sel ? fbB_q : fbA_q;
    assign frame_num = r_frame_num;
    assign wr_ready  = r_wr_ready;
    assign clearing  = r_clearing;
    assign swap_done = r_swap_done;

endmodule
`default_nettype wire

// File: tb/tb_fb_buffer_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_buffer_ctl
//  Description : Scoreboard bench for fb_buffer_ctl with behavioural RAM pairs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fb_buffer_ctl;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut0: CLEAR_COLOR 8'h00
    logic          rst_n0, vbl0, wr_req0, fdone0;
    logic [AW-1:0] rd_addr0, wr_addr0, a_addr0, b_addr0;
    logic [DW-1:0] wr_data0, rd_data0, a_data0, b_data0, a_q0, b_q0;
    logic          wr_ready0, fnum0, clearing0, swap_done0, a_wren0, b_wren0;
    // dut1: CLEAR_COLOR 8'h3C
    logic          rst_n1, vbl1, wr_req1, fdone1;
    logic [AW-1:0] rd_addr1, wr_addr1, a_addr1, b_addr1;
    logic [DW-1:0] wr_data1, rd_data1, a_data1, b_data1, a_q1, b_q1;
    logic          wr_ready1, fnum1, clearing1, swap_done1, a_wren1, b_wren1;

    fb_buffer_ctl #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH), .CLEAR_COLOR(8'h00)) dut0 (
        .SYS_CLK(clk), .RESET_N(rst_n0), .vblank_start(vbl0),
        .rd_addr(rd_addr0), .rd_data(rd_data0),
        .wr_req(wr_req0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_ready(wr_ready0),
        .frame_done(fdone0), .frame_num(fnum0), .clearing(clearing0), .swap_done(swap_done0),
        .fbA_addr(a_addr0), .fbB_addr(b_addr0), .fbA_data(a_data0), .fbB_data(b_data0),
        .fbA_wren(a_wren0), .fbB_wren(b_wren0), .fbA_q(a_q0), .fbB_q(b_q0)
    );

    fb_buffer_ctl #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH), .CLEAR_COLOR(8'h3C)) dut1 (
        .SYS_CLK(clk), .RESET_N(rst_n1), .vblank_start(vbl1),
        .rd_addr(rd_addr1), .rd_data(rd_data1),
        .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_ready(wr_ready1),
        .frame_done(fdone1), .frame_num(fnum1), .clearing(clearing1), .swap_done(swap_done1),
        .fbA_addr(a_addr1), .fbB_addr(b_addr1), .fbA_data(a_data1), .fbB_data(b_data1),
        .fbA_wren(a_wren1), .fbB_wren(b_wren1), .fbA_q(a_q1), .fbB_q(b_q1)
    );

    logic [DW-1:0] mem_a0 [256];
    logic [DW-1:0] mem_b0 [256];
    logic [DW-1:0] mem_a1 [256];
    logic [DW-1:0] mem_b1 [256];

    always @(posedge clk) begin
        if (a_wren0) mem_a0[a_addr0] <= a_data0;
        if (b_wren0) mem_b0[b_addr0] <= b_data0;
        if (a_wren1) mem_a1[a_addr1] <= a_data1;
        if (b_wren1) mem_b1[b_addr1] <= b_data1;
        a_q0 <= mem_a0[a_addr0];
        b_q0 <= mem_b0[b_addr0];
        a_q1 <= mem_a1[a_addr1];
        b_q1 <= mem_b1[b_addr1];
    end

    typedef struct packed {
        logic          ram;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_wr0[$];
    logic [DW-1:0] exp_rd0[$];
    logic [DW-1:0] exp_rd1[$];
    logic          exp_sw0[$];
    logic          exp_sw1[$];

    logic rd_req0 = 1'b0, rd_req1 = 1'b0;
    logic rd_vld0 = 1'b0, rd_vld1 = 1'b0;
    always @(posedge clk) begin
        rd_vld0 <= rd_req0;
        rd_vld1 <= rd_req1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event with no expectation queued (t=%0t)", name, $time);
    endtask

    task automatic mon_write(input logic ram, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_t e;
        if (exp_wr0.size() == 0) begin
            unexpected("ram_write");
        end else begin
            e = exp_wr0.pop_front();
            check("wr_ram", ram, e.ram);
            check("wr_addr", addr, e.addr);
            check("wr_data", data, e.data);
        end
    endtask

    // Monitor: every RAM write, read return and swap pulse is matched against the queues.
    always @(negedge clk) begin
        if (a_wren0) mon_write(1'b0, a_addr0, a_data0);
        if (b_wren0) mon_write(1'b1, b_addr0, b_data0);
        if (rd_vld0) begin
            if (exp_rd0.size() == 0) unexpected("rd_data0");
            else check("rd_data0", rd_data0, exp_rd0.pop_front());
        end
        if (rd_vld1) begin
            if (exp_rd1.size() == 0) unexpected("rd_data1");
            else check("rd_data1", rd_data1, exp_rd1.pop_front());
        end
        if (swap_done0) begin
            if (exp_sw0.size() == 0) unexpected("swap_done0");
            else check("swap_fnum0", fnum0, exp_sw0.pop_front());
        end
        if (swap_done1) begin
            if (exp_sw1.size() == 0) unexpected("swap_done1");
            else check("swap_fnum1", fnum1, exp_sw1.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear0(input logic ram, input int n);
        for (int i = 0; i < n; i++) exp_wr0.push_back({ram, AW'(i), 8'h00});
    endtask

    task automatic wait_ready0();
        int i;
        for (i = 0; i < 60 && !wr_ready0; i++) tick();
        if (!wr_ready0) unexpected("timeout_wr_ready0");
    endtask

    task automatic wait_ready1();
        int i;
        for (i = 0; i < 60 && !wr_ready1; i++) tick();
        if (!wr_ready1) unexpected("timeout_wr_ready1");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [DW-1:0] pix;
        rst_n0 = 1'b0; vbl0 = 1'b0; wr_req0 = 1'b0; fdone0 = 1'b0;
        rd_addr0 = '0; wr_addr0 = '0; wr_data0 = '0;
        rst_n1 = 1'b0; vbl1 = 1'b0; wr_req1 = 1'b0; fdone1 = 1'b0;
        rd_addr1 = '0; wr_addr1 = '0; wr_data1 = '0;
        repeat (3) tick();

        @(negedge clk);
        check("rst_frame_num", fnum0, 0);
        check("rst_wr_ready", wr_ready0, 0);
        check("rst_swap_done", swap_done0, 0);
        check("rst_wrenA", a_wren0, 0);
        check("rst_wrenB", b_wren0, 0);

        // Initial clear of B, exactly DEPTH cycles
        push_clear0(1'b1, DEPTH);
        tick();
        rst_n0 = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wr_ready0) break;
            if (clearing0) n++;
        end
        check("clear_cycles", n, DEPTH);
        check("draw_frame_num", fnum0, 0);
        check("draw_wr_ready", wr_ready0, 1);

        // Write alongside frame_done is still accepted
        tick();
        exp_wr0.push_back({1'b1, 8'd5, 8'hF0});
        wr_req0 = 1'b1; wr_addr0 = 8'd5; wr_data0 = 8'hF0; fdone0 = 1'b1;
        tick();
        wr_req0 = 1'b0; fdone0 = 1'b0;
        @(negedge clk);
        check("wait_wr_ready", wr_ready0, 0);
        tick();
        wr_req0 = 1'b1; wr_addr0 = 8'd3; wr_data0 = 8'hAA;
        repeat (2) tick();
        wr_req0 = 1'b0;

        // Swap to B displayed; A cleared while B is read back at addr 5
        exp_sw0.push_back(1'b1);
        push_clear0(1'b0, DEPTH);
        vbl0 = 1'b1;
        tick();
        vbl0 = 1'b0;
        rd_addr0 = 8'd5; rd_req0 = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            exp_rd0.push_back(8'hF0);
            tick();
        end
        rd_req0 = 1'b0;
        check("post_swap_frame_num", fnum0, 1);

        // frame_done together with vblank_start: no swap yet
        wait_ready0();
        fdone0 = 1'b1; vbl0 = 1'b1;
        tick();
        fdone0 = 1'b0; vbl0 = 1'b0;
        wr_req0 = 1'b1; wr_addr0 = 8'd3; wr_data0 = 8'h77;
        repeat (2) tick();
        wr_req0 = 1'b0;
        @(negedge clk);
        check("coinc_frame_num", fnum0, 1);
        check("coinc_wr_ready", wr_ready0, 0);
        tick();
        exp_sw0.push_back(1'b0);
        push_clear0(1'b1, DEPTH);
        vbl0 = 1'b1;
        tick();
        vbl0 = 1'b0;
        wait_ready0();
        check("second_swap_frame_num", fnum0, 0);

        // Swap again, then reset in the middle of clearing A
        fdone0 = 1'b1;
        tick();
        fdone0 = 1'b0;
        exp_sw0.push_back(1'b1);
        push_clear0(1'b0, 7);
        vbl0 = 1'b1;
        tick();
        vbl0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (a_wren0 && a_addr0 == 8'd7) break;
            tick();
        end
        rst_n0 = 1'b0;
        @(negedge clk);
        check("midrst_frame_num", fnum0, 0);
        check("midrst_wrenA", a_wren0, 0);
        check("midrst_wrenB", b_wren0, 0);
        push_clear0(1'b1, DEPTH);
        tick();
        rst_n0 = 1'b1;
        wait_ready0();
        check("wr_queue0_empty", exp_wr0.size(), 0);

        // dut1: three frames with CLEAR_COLOR 8'h3C
        rst_n1 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_ready1();
            check("frame_num1", fnum1, f % 2);
            pix = 8'h50 + 8'(f);
            wr_req1 = 1'b1; wr_addr1 = 8'd2; wr_data1 = pix;
            tick();
            wr_req1 = 1'b0; fdone1 = 1'b1;
            tick();
            fdone1 = 1'b0;
            exp_sw1.push_back((f % 2) == 0);
            vbl1 = 1'b1;
            tick();
            vbl1 = 1'b0;
            rd_req1 = 1'b1; rd_addr1 = 8'd9;
            exp_rd1.push_back(8'h3C);
            tick();
            rd_addr1 = 8'd2;
            exp_rd1.push_back(pix);
            tick();
            rd_req1 = 1'b0;
        end
        repeat (3) tick();
        check("final_frame_num1", fnum1, 1);
        check("rd_queue0_empty", exp_rd0.size(), 0);
        check("rd_queue1_empty", exp_rd1.size(), 0);
        check("sw_queue0_empty", exp_sw0.size(), 0);
        check("sw_queue1_empty", exp_sw1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
